// File: rtl/mxint_to_fixed.sv
// MxInt block to signed fixed-point dequantiser: two-stage valid/ready pipeline
// with symmetric saturation and a sticky count of saturated output blocks.
module mxint_to_fixed #(
    parameter int unsigned IN_MAN_WIDTH   = 8,
    parameter int unsigned IN_EXP_WIDTH   = 4,
    parameter int unsigned OUT_WIDTH      = 8,
    parameter int unsigned OUT_FRAC_WIDTH = 4,
    parameter int unsigned BLOCK_SIZE     = 4,
    parameter int unsigned SAT_CNT_WIDTH  = 16
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic signed [IN_MAN_WIDTH-1:0]  mdata_in [BLOCK_SIZE],
    input  logic        [IN_EXP_WIDTH-1:0]  edata_in,
    input  logic                            data_in_valid,
    output logic                            data_in_ready,
    output logic signed [OUT_WIDTH-1:0]     data_out [BLOCK_SIZE],
    output logic                            data_out_valid,
    input  logic                            data_out_ready,
    input  logic                            sat_clear,
    output logic        [SAT_CNT_WIDTH-1:0] sat_count
);

    localparam int unsigned SW    = IN_EXP_WIDTH + $clog2(IN_MAN_WIDTH + OUT_WIDTH + OUT_FRAC_WIDTH + 1) + 2;
    localparam int unsigned WW    = IN_MAN_WIDTH + OUT_WIDTH + 1;
    localparam int unsigned EBIAS = 2**(IN_EXP_WIDTH-1) - 1;
    localparam int unsigned S_SUB = EBIAS + IN_MAN_WIDTH - 2;

    // S = e - S_OFS; any shift at or above S_CLAMP overflows for every non-zero mantissa
    localparam logic signed [SW-1:0] S_OFS   = $signed(SW'(S_SUB)) - $signed(SW'(OUT_FRAC_WIDTH));
    localparam logic signed [SW-1:0] S_CLAMP = SW'(OUT_WIDTH - 1);
    localparam logic signed [SW-1:0] S_FLOOR = $signed(SW'(0)) - $signed(SW'(IN_MAN_WIDTH));
    localparam logic signed [WW-1:0] MAX_W   = WW'(2**(OUT_WIDTH-1) - 1);

    logic                           s1_valid_q, s1_valid_d;
    logic signed [IN_MAN_WIDTH-1:0] man_q [BLOCK_SIZE];
    logic signed [IN_MAN_WIDTH-1:0] man_d [BLOCK_SIZE];
    logic signed [SW-1:0]           shift_q, shift_d;

    logic                           out_valid_q, out_valid_d;
    logic signed [OUT_WIDTH-1:0]    out_q [BLOCK_SIZE];
    logic signed [OUT_WIDTH-1:0]    out_d [BLOCK_SIZE];
    logic                           blk_sat_q, blk_sat_d;
    logic [SAT_CNT_WIDTH-1:0]       sat_cnt_q, sat_cnt_d;

    logic                           s2_adv_c;
    logic                           s1_load_c;
    logic signed [OUT_WIDTH-1:0]    conv_c [BLOCK_SIZE];
    logic                           conv_sat_c;

    // Handshake: input ready follows downstream ready combinationally, so no bubbles
    always_comb begin
        s2_adv_c      = !out_valid_q || data_out_ready;
        data_in_ready = !s1_valid_q || s2_adv_c;
        s1_load_c     = data_in_valid && data_in_ready;
    end

    // Stage 1: capture mantissas and the signed shift amount
    always_comb begin
        s1_valid_d = s1_valid_q;
        man_d      = man_q;
        shift_d    = shift_q;
        if (data_in_ready) begin
            s1_valid_d = data_in_valid;
        end
        if (s1_load_c) begin
            man_d   = mdata_in;
            shift_d = $signed(SW'(edata_in)) - S_OFS;
        end
    end

    // Per-element shift with symmetric clamp to +/-MAX
    always_comb begin : convert
        logic signed [WW-1:0] m_w;
        logic signed [WW-1:0] mag_w;
        logic signed [WW-1:0] sh_w;
        logic signed [WW-1:0] res_w;
        logic        [SW-1:0] rsh;
        logic                 neg;
        logic                 el_sat;
        m_w        = '0;
        mag_w      = '0;
        sh_w       = '0;
        res_w      = '0;
        rsh        = '0;
        neg        = 1'b0;
        el_sat     = 1'b0;
        conv_sat_c = 1'b0;
        for (int i = 0; i < BLOCK_SIZE; i++) begin
            neg    = man_q[i][IN_MAN_WIDTH-1];
            m_w    = WW'(man_q[i]);
            mag_w  = neg ? -m_w : m_w;
            sh_w   = '0;
            res_w  = '0;
            el_sat = 1'b0;
            rsh    = -shift_q;
            if (man_q[i] == '0) begin
                res_w = '0;
            end else if (!shift_q[SW-1]) begin
                if (shift_q >= S_CLAMP) begin
                    el_sat = 1'b1;
                end else begin
                    sh_w = mag_w << shift_q;
                    if (sh_w > MAX_W) begin
                        el_sat = 1'b1;
                    end else begin
                        res_w = neg ? -sh_w : sh_w;
                    end
                end
            end else if (shift_q < S_FLOOR) begin
                res_w = neg ? {WW{1'b1}} : '0;
            end else begin
                res_w = m_w >>> rsh;
                if (res_w > MAX_W || res_w < -MAX_W) begin
                    el_sat = 1'b1;
                end
            end
            if (el_sat) begin
                res_w = neg ? -MAX_W : MAX_W;
            end
            conv_c[i]  = res_w[OUT_WIDTH-1:0];
            conv_sat_c = conv_sat_c | el_sat;
        end
    end

    // Stage 2 and the sticky saturation counter (clear wins over increment)
    always_comb begin
        out_valid_d = out_valid_q;
        out_d       = out_q;
        blk_sat_d   = blk_sat_q;
        sat_cnt_d   = sat_cnt_q;
        if (s2_adv_c) begin
            out_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                out_d     = conv_c;
                blk_sat_d = conv_sat_c;
            end
        end
        if (sat_clear) begin
            sat_cnt_d = '0;
        end else if (out_valid_q && data_out_ready && blk_sat_q && (sat_cnt_q != '1)) begin
            sat_cnt_d = sat_cnt_q + SAT_CNT_WIDTH'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_q  <= 1'b0;
            shift_q     <= '0;
            out_valid_q <= 1'b0;
            blk_sat_q   <= 1'b0;
            sat_cnt_q   <= '0;
            for (int i = 0; i < BLOCK_SIZE; i++) begin
                man_q[i] <= '0;
                out_q[i] <= '0;
            end
        end else begin
            s1_valid_q  <= s1_valid_d;
            man_q       <= man_d;
            shift_q     <= shift_d;
            out_valid_q <= out_valid_d;
            out_q       <= out_d;
            blk_sat_q   <= blk_sat_d;
            sat_cnt_q   <= sat_cnt_d;
        end
    end

    assign data_out       = out_q;
    assign data_out_valid = out_valid_q;
    assign sat_count      = sat_cnt_q;

endmodule
